// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its neighbours.
//   ctrl_t    : 9-bit control bundle {reg_write, mem_read, mem_write,
//               mem_to_reg, alu_src, alu_op[3:0]} as carried from ID into EX.
//   CTRL_*    : bit offsets of each field inside the packed bundle.
//   ALU_OP_*  : ALU operation encodings used in ctrl_t.alu_op.
//   REG_ZERO  : index of the hardwired-zero register.
package pipe_pkg;

    localparam int CTRL_W             = 9;
    localparam int CTRL_ALU_OP_LSB    = 0;
    localparam int CTRL_ALU_SRC_BIT   = 4;
    localparam int CTRL_MEM_TO_REG_BIT = 5;
    localparam int CTRL_MEM_WRITE_BIT = 6;
    localparam int CTRL_MEM_READ_BIT  = 7;
    localparam int CTRL_REG_WRITE_BIT = 8;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_OR  = 4'd3;
    localparam logic [3:0] ALU_OP_XOR = 4'd4;
    localparam logic [3:0] ALU_OP_SLT = 4'd5;
    localparam logic [3:0] ALU_OP_SLL = 4'd6;
    localparam logic [3:0] ALU_OP_SRL = 4'd7;
    localparam logic [3:0] ALU_OP_SRA = 4'd8;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    // Control word of a bubble: writes nothing, reads nothing.
    function automatic ctrl_t ctrl_nop();
        return '0;
    endfunction

endpackage

// File: rtl/idex_hazard_stage_if.sv
// ID -> EX bus of the ID/EX pipeline register.
//   master : ID side (drives id_*, flush; observes EX outputs and stall enables)
//   slave  : the ID/EX stage itself
// Signals:
//   id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_rdata1, id_rdata2,
//   id_imm, id_ctrl, flush                                      (ID -> stage)
//   ex_valid, RS1_IDEX, RS2_IDEX, RD_IDEX, ex_rdata1, ex_rdata2, ex_imm,
//   ex_ctrl, pc_write, ifid_write, perf_bubbles                 (stage -> EX/IF)
interface idex_hazard_stage_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic              id_uses_rs2;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    ctrl_t             id_ctrl;
    logic              flush;

    logic              ex_valid;
    logic [REG_W-1:0]  RS1_IDEX;
    logic [REG_W-1:0]  RS2_IDEX;
    logic [REG_W-1:0]  RD_IDEX;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    ctrl_t             ex_ctrl;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  perf_bubbles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd,
               id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
        input  ex_valid, RS1_IDEX, RS2_IDEX, RD_IDEX, ex_rdata1, ex_rdata2,
               ex_imm, ex_ctrl, pc_write, ifid_write, perf_bubbles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd,
               id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
        output ex_valid, RS1_IDEX, RS2_IDEX, RD_IDEX, ex_rdata1, ex_rdata2,
               ex_imm, ex_ctrl, pc_write, ifid_write, perf_bubbles
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the load sitting in EX writes a register that the instruction
// in ID reads; a load to x0 or an empty ID slot never stalls.
// Ports:
//   ex_valid, ex_mem_read, ex_rd : instruction currently in EX
//   id_valid, id_rs1, id_rs2, id_uses_rs2 : instruction currently in ID
//   hazard : 1 = ID must wait one cycle for the load data
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    output logic             hazard
);

    logic load_in_ex;
    logic rs1_match;
    logic rs2_match;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        load_in_ex = 1'b0;
        rs1_match  = 1'b0;
        rs2_match  = 1'b0;
        hazard     = 1'b0;

        load_in_ex = ex_valid && ex_mem_read && (ex_rd != REG_W'(REG_ZERO));
        rs1_match  = (ex_rd == id_rs1);
        // rs2 only counts when the instruction actually reads it (I-type
        // encodings carry immediate bits in that field).
        rs2_match  = id_uses_rs2 && (ex_rd == id_rs2);
        hazard     = load_in_ex && id_valid && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with integrated load-use hazard handling.
// Latches operands, register indices and control from ID for EX. On a
// load-use hazard it inserts one bubble and freezes PC and IF/ID; on a
// taken-branch flush it squashes ID into a bubble and lets the redirect run.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : idex_hazard_stage_if.slave (ID inputs, EX outputs, pc_write,
//          ifid_write, perf_bubbles)
// Configuration:
//   STALL_COUNT_EN : when defined, perf_bubbles counts inserted load-use
//                    bubbles (saturating); otherwise it is tied to zero.
module idex_hazard_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    idex_hazard_stage_if.slave    bus
);

    logic              ex_valid_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] imm_q;
    ctrl_t             ctrl_q;

    logic hazard;
    logic stall;
    logic bubble;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs2 (bus.id_uses_rs2),
        .hazard      (hazard)
    );

    // A flush wins over a hazard: the stalled instruction is being squashed
    // anyway, so the front end must be free to fetch the branch target.
    assign stall  = hazard && !bus.flush;
    assign bubble = hazard || bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data flops are reset as well because they drive module
            // outputs directly; there is no storage array here to leave alone.
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            ctrl_q     <= ctrl_nop();
        end else if (bubble) begin
            // Only the fields that can cause side effects or hazards are
            // cleared; operand data are held since nothing consumes them.
            ex_valid_q <= 1'b0;
            rd_q       <= '0;
            ctrl_q     <= ctrl_nop();
        end else begin
            ex_valid_q <= bus.id_valid;
            rs1_q      <= bus.id_rs1;
            rs2_q      <= bus.id_rs2;
            rd_q       <= bus.id_rd;
            rdata1_q   <= bus.id_rdata1;
            rdata2_q   <= bus.id_rdata2;
            imm_q      <= bus.id_imm;
            // An empty ID slot must not carry write enables into EX.
            ctrl_q     <= bus.id_valid ? bus.id_ctrl : ctrl_nop();
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.RS1_IDEX   = rs1_q;
    assign bus.RS2_IDEX   = rs2_q;
    assign bus.RD_IDEX    = rd_q;
    assign bus.ex_rdata1  = rdata1_q;
    assign bus.ex_rdata2  = rdata2_q;
    assign bus.ex_imm     = imm_q;
    assign bus.ex_ctrl    = ctrl_q;
    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign bus.perf_bubbles = bubble_cnt_q;
`else
    assign bus.perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed self-checking bench for idex_hazard_stage.
// Uses CNT_W = 2 so counter saturation is reachable; expected counter values
// follow STALL_COUNT_EN (zero when the macro is undefined).
module tb_idex_hazard_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 2;

`ifdef STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    idex_hazard_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    idex_hazard_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk_ctrl(input logic rw, input logic mr, input logic mw,
                                      input logic m2r, input logic src, input logic [3:0] op);
        ctrl_t c;
        c.reg_write  = rw;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.mem_to_reg = m2r;
        c.alu_src    = src;
        c.alu_op     = op;
        return c;
    endfunction

    ctrl_t c_lw;
    ctrl_t c_sw;
    ctrl_t c_r;
    ctrl_t c_i;

    // Expected saturating bubble count after n counted hazards.
    function automatic logic [63:0] exp_cnt(input int n);
        if (!CNT_EN) return 64'd0;
        return (n > 3) ? 64'd3 : 64'(n);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                          input logic u2, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d1,
                          input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] imm, input ctrl_t c);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs2 = u2;
        bus.id_rd       = rd;
        bus.id_rdata1   = d1;
        bus.id_rdata2   = d2;
        bus.id_imm      = imm;
        bus.id_ctrl     = c;
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'd0);
        check({tag, ".rd"},       64'(bus.RD_IDEX),  64'd0);
        check({tag, ".rs1"},      64'(bus.RS1_IDEX), 64'd0);
        check({tag, ".rdata1"},   64'(bus.ex_rdata1), 64'd0);
        check({tag, ".imm"},      64'(bus.ex_imm),   64'd0);
        check({tag, ".ctrl"},     64'(bus.ex_ctrl),  64'd0);
        check({tag, ".pc_write"}, 64'(bus.pc_write), 64'd1);
        check({tag, ".perf"},     64'(bus.perf_bubbles), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        c_lw = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_OP_ADD);
        c_sw = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_OP_ADD);
        c_r  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_ADD);
        c_i  = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_XOR);

        bus.flush = 1'b0;
        rst = 1'b1;
        set_id(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        check_cleared("reset");
        check("reset.ifid_write", 64'(bus.ifid_write), 64'd1);
        tick();
        rst = 1'b0;

        // lw x5, 4(x1) then add x6, x5, x7: one bubble, one-cycle stall.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h100, 32'h0, 32'h4, c_lw);
        check("lw.no_stall", 64'(bus.pc_write), 64'd1);
        tick();
        check("lw.ex_valid", 64'(bus.ex_valid), 64'd1);
        check("lw.rd", 64'(bus.RD_IDEX), 64'd5);
        check("lw.ctrl", 64'(bus.ex_ctrl), 64'(c_lw));
        check("lw.imm", 64'(bus.ex_imm), 64'h4);
        check("lw.rdata1", 64'(bus.ex_rdata1), 64'h100);
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 32'hAAAA, 32'h7777, 32'h0, c_r);
        check("add.pc_write", 64'(bus.pc_write), 64'd0);
        check("add.ifid_write", 64'(bus.ifid_write), 64'd0);
        tick();
        check("bubble.ex_valid", 64'(bus.ex_valid), 64'd0);
        check("bubble.ctrl", 64'(bus.ex_ctrl), 64'd0);
        check("bubble.rd", 64'(bus.RD_IDEX), 64'd0);
        check("bubble.perf", 64'(bus.perf_bubbles), exp_cnt(1));
        check("bubble.pc_write", 64'(bus.pc_write), 64'd1);
        check("bubble.ifid_write", 64'(bus.ifid_write), 64'd1);
        tick();
        check("add.ex_valid", 64'(bus.ex_valid), 64'd1);
        check("add.rd", 64'(bus.RD_IDEX), 64'd6);
        check("add.rs1", 64'(bus.RS1_IDEX), 64'd5);
        check("add.rs2", 64'(bus.RS2_IDEX), 64'd7);
        check("add.rdata2", 64'(bus.ex_rdata2), 64'h7777);
        check("add.ctrl", 64'(bus.ex_ctrl), 64'(c_r));

        // lw x5 then sw x5 via rs2: stall.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h200, 32'h0, 32'h8, c_lw);
        tick();
        set_id(1'b1, 5'd2, 5'd5, 1'b1, 5'd0, 32'h300, 32'h55, 32'hC, c_sw);
        check("sw.pc_write", 64'(bus.pc_write), 64'd0);
        tick();
        check("sw.bubble", 64'(bus.ex_valid), 64'd0);
        check("sw.perf", 64'(bus.perf_bubbles), exp_cnt(2));
        tick();
        check("sw.ctrl", 64'(bus.ex_ctrl), 64'(c_sw));

        // Same but rs2 field not read: no stall.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h200, 32'h0, 32'h8, c_lw);
        tick();
        set_id(1'b1, 5'd2, 5'd5, 1'b0, 5'd8, 32'h300, 32'h0, 32'h10, c_i);
        check("nors2.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        check("nors2.ex_valid", 64'(bus.ex_valid), 64'd1);
        check("nors2.rd", 64'(bus.RD_IDEX), 64'd8);

        // lw x0 then add using x0: no stall.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, c_lw);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0, 32'h0, 32'h0, c_r);
        check("x0.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        check("x0.rd", 64'(bus.RD_IDEX), 64'd9);

        // ALU producer into x5 then dependent add: forwarding, no stall.
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd5, 32'h1, 32'h0, 32'h2, c_i);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, c_r);
        check("alu.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        check("alu.ex_valid", 64'(bus.ex_valid), 64'd1);
        check("alu.rd", 64'(bus.RD_IDEX), 64'd6);

        // Load followed by an empty ID slot carrying stale fields: no stall,
        // and the resulting bubble carries no write enables.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
        tick();
        set_id(1'b0, 5'd5, 5'd5, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, c_r);
        check("idle.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        check("idle.ex_valid", 64'(bus.ex_valid), 64'd0);
        check("idle.ctrl", 64'(bus.ex_ctrl), 64'd0);

        // Hazard and flush together: bubble, no stall, not counted.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, c_lw);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, c_r);
        bus.flush = 1'b1;
        #1;
        check("flush.pc_write", 64'(bus.pc_write), 64'd1);
        check("flush.ifid_write", 64'(bus.ifid_write), 64'd1);
        tick();
        bus.flush = 1'b0;
        check("flush.ex_valid", 64'(bus.ex_valid), 64'd0);
        check("flush.ctrl", 64'(bus.ex_ctrl), 64'd0);
        check("flush.perf", 64'(bus.perf_bubbles), exp_cnt(2));

        // Reset in the middle of a stall.
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 32'h44, 32'h0, 32'h4, c_lw);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 32'h0, 32'h0, 32'h0, c_r);
        check("midrst.stall", 64'(bus.pc_write), 64'd0);
        rst = 1'b1;
        #1;
        check_cleared("midrst");
        check("midrst.ifid_write", 64'(bus.ifid_write), 64'd1);
        set_id(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
        tick();
        rst = 1'b0;

        // Five hazards against a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd10, 32'h0, 32'h0, 32'h0, c_lw);
            tick();
            set_id(1'b1, 5'd2, 5'd10, 1'b1, 5'd11, 32'h0, 32'h0, 32'h0, c_sw);
            tick();
            check("sat.perf_step", 64'(bus.perf_bubbles), exp_cnt(i + 1));
            tick();
        end
        check("sat.perf_final", 64'(bus.perf_bubbles), CNT_EN ? 64'd3 : 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
